// File: rtl/uart_baud_gen_pkg.sv
// Shared UART constants: default divisor geometry and a width helper.
package uart_baud_gen_pkg;

    localparam int unsigned UART_DIV_W       = 16;
    localparam int unsigned UART_FRAC_W      = 4;
    localparam int unsigned UART_OVERSAMPLE  = 16;
    localparam int unsigned UART_DEFAULT_DIV = 5300;

    // Bits needed to index 'value' items (value >= 1).
    function automatic int unsigned uart_clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Integer+fractional clock divider: emits one registered tick per oversample interval.
module uart_frac_div
    import uart_baud_gen_pkg::*;
#(
    parameter int unsigned DIV_W  = UART_DIV_W,
    parameter int unsigned FRAC_W = UART_FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [DIV_W-1:0]  a_int,
    input  logic [FRAC_W-1:0] a_frac,
    output logic              tick,
    output logic              wrap_c
);

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              xtra;
    logic              term;

    // a_int is never below 2, so a_int-1 cannot underflow; xtra stretches by one cycle.
    always_comb begin
        term   = xtra ? (cnt == a_int) : (cnt == a_int - DIV_W'(1));
        wrap_c = enable && !clear && term;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            acc  <= '0;
            xtra <= 1'b0;
            tick <= 1'b0;
        end else if (!enable || clear) begin
            cnt  <= '0;
            acc  <= '0;
            xtra <= 1'b0;
            tick <= 1'b0;
        end else if (term) begin
            cnt         <= '0;
            {xtra, acc} <= {1'b0, acc} + {1'b0, a_frac};
            tick        <= 1'b1;
        end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud tick generator: programmable divisor with shadow reload, oversample phase and bit/mid-bit enables.
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int unsigned DIV_W       = UART_DIV_W,
    parameter int unsigned FRAC_W      = UART_FRAC_W,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                load,
    input  logic [DIV_W-1:0]                    div_int,
    input  logic [FRAC_W-1:0]                   div_frac,
    input  logic                                resync,
    output logic                                os_tick,
    output logic                                bit_tick,
    output logic                                mid_tick,
    output logic [uart_clog2(OVERSAMPLE)-1:0]   os_phase
);

    localparam int unsigned PH_W = uart_clog2(OVERSAMPLE);

    logic [DIV_W-1:0]  a_int;
    logic [FRAC_W-1:0] a_frac;
    logic [DIV_W-1:0]  s_int;
    logic [FRAC_W-1:0] s_frac;
    logic              pend;
    logic [DIV_W-1:0]  div_clamp_c;
    logic              apply_c;
    logic              wrap_c;

    // Divisors below 2 would give back-to-back ticks; clamp on capture.
    always_comb begin
        div_clamp_c = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
        apply_c     = pend && (!enable || resync || wrap_c);
    end

    // Shadow reloads only at an interval boundary, or at once while idle or resyncing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_int  <= DIV_W'(DEFAULT_DIV);
            a_frac <= '0;
            s_int  <= DIV_W'(DEFAULT_DIV);
            s_frac <= '0;
            pend   <= 1'b0;
        end else begin
            if (apply_c) begin
                a_int  <= s_int;
                a_frac <= s_frac;
            end
            if (load) begin
                s_int  <= div_clamp_c;
                s_frac <= div_frac;
                pend   <= 1'b1;
            end else if (apply_c) begin
                pend <= 1'b0;
            end
        end
    end

    uart_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (resync),
        .a_int  (a_int),
        .a_frac (a_frac),
        .tick   (os_tick),
        .wrap_c (wrap_c)
    );

    // Phase advances on the same edge that raises os_tick, so bit/mid line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_phase <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else if (!enable || resync) begin
            os_phase <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else if (wrap_c) begin
            os_phase <= os_phase + PH_W'(1);
            bit_tick <= (os_phase == PH_W'(OVERSAMPLE - 1));
            mid_tick <= (os_phase == PH_W'(OVERSAMPLE / 2 - 1));
        end else begin
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: interval-level model plus directed literal checks.
module tb_uart_baud_gen;

    localparam int OS   = 16;
    localparam int FR   = 16;
    localparam int DEFD = 5300;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] div_int = 16'd0;
    logic [3:0]  div_frac = 4'd0;
    logic        resync = 1'b0;
    logic        os_tick;
    logic        bit_tick;
    logic        mid_tick;
    logic [3:0]  os_phase;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_baud_gen dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .load     (load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .resync   (resync),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .os_phase (os_phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Interval-level model: countdown to the next tick, fractional carry as plain arithmetic.
    int m_aint, m_afrac, m_sint, m_sfrac, m_acc, m_ticks, m_left;
    bit m_pend, m_apply, m_carry, e_os, e_bit, e_mid;

    always @(posedge clk) begin
        if (!reset) begin
            m_aint = DEFD; m_afrac = 0; m_sint = DEFD; m_sfrac = 0; m_pend = 0;
            m_acc = 0; m_ticks = 0; m_left = DEFD;
            e_os = 0; e_bit = 0; e_mid = 0;
        end else begin
            m_apply = 0; m_carry = 0; e_os = 0; e_bit = 0; e_mid = 0;
            if (!enable || resync) begin
                m_acc = 0; m_ticks = 0; m_apply = m_pend;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    e_os    = 1;
                    m_ticks = m_ticks + 1;
                    e_bit   = (m_ticks % OS) == 0;
                    e_mid   = (m_ticks % OS) == OS / 2;
                    m_carry = (m_acc + m_afrac) >= FR;
                    m_acc   = (m_acc + m_afrac) % FR;
                    m_apply = m_pend;
                end
            end
            if (m_apply) begin
                m_aint = m_sint; m_afrac = m_sfrac; m_pend = 0;
            end
            if (!enable || resync) m_left = m_aint;
            else if (e_os) m_left = m_aint + int'(m_carry);
            if (load) begin
                m_sint = (int'(div_int) < 2) ? 2 : int'(div_int);
                m_sfrac = int'(div_frac);
                m_pend = 1;
            end
        end
        #1;
        total++;
        if (os_tick !== e_os || bit_tick !== e_bit || mid_tick !== e_mid
            || int'(os_phase) != (m_ticks % OS)) begin
            bad++;
            $display("FAIL cycle %0d: got os=%0b bit=%0b mid=%0b phase=%0d, required os=%0b bit=%0b mid=%0b phase=%0d",
                     cyc, os_tick, bit_tick, mid_tick, os_phase, e_os, e_bit, e_mid, m_ticks % OS);
            if (bad > 100) summary_and_finish();
        end
    end

    // Waits for a pulse on os(0)/bit(1)/mid(2); 'at' is the cycle stamp where it was seen.
    task automatic wait_for(input int sel, input int limit, input string nm, output int at);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            hit = (sel == 0) ? os_tick : (sel == 1) ? bit_tick : mid_tick;
        end
        at = cyc;
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: no pulse in %0d cycles, required one", nm, limit);
        end
    endtask

    // Loads a divisor while briefly disabled so it applies at once; returns the enable stamp.
    task automatic set_div(input int di, input int df, output int start);
        @(negedge clk);
        load = 1'b1; div_int = 16'(di); div_frac = 4'(df); enable = 1'b0;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        start = cyc;
    endtask

    initial begin
        #950000;
        total++;
        bad++;
        $display("FAIL watchdog: run exceeded cycle budget, required finish");
        summary_and_finish();
    end

    initial begin
        int s, r, t0, t1, t2, t3, sum, mid_at, bit_at;

        repeat (3) @(negedge clk);
        chk("reset_os_tick", int'(os_tick), 0);
        chk("reset_phase", int'(os_phase), 0);
        reset = 1'b1;

        // Async reset mid-interval with a non-default divisor loaded.
        set_div(3, 0, s);
        wait_for(0, 20, "div3_first", t1);
        chk("div3_first", t1 - s, 3);
        wait_for(0, 20, "div3_second", t2);
        chk("div3_period", t2 - t1, 3);
        chk("pre_reset_phase", int'(os_phase), 2);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_os_tick", int'(os_tick), 0);
        chk("async_reset_phase", int'(os_phase), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        r = cyc;

        // Default divisor restored: ticks every 5300, first bit tick at 84800.
        wait_for(0, 6000, "default_first", t1);
        chk("default_first_tick", t1 - r, DEFD);
        wait_for(0, 6000, "default_second", t2);
        chk("default_period", t2 - t1, DEFD);
        wait_for(1, 80000, "default_bit", t3);
        chk("default_first_bit", t3 - r, OS * DEFD);
        chk("default_bit_phase", int'(os_phase), 0);

        // Fractional divisor 4 + 8/16.
        set_div(4, 8, s);
        wait_for(0, 20, "frac0", t0);
        chk("frac_len0", t0 - s, 4);
        sum = 0;
        for (int k = 1; k <= 16; k++) begin
            wait_for(0, 20, "frac", t1);
            if (k == 1) chk("frac_len1", t1 - t0, 4);
            if (k == 2) chk("frac_len2", t1 - t0, 5);
            if (k == 3) chk("frac_len3", t1 - t0, 4);
            sum += t1 - t0;
            t0 = t1;
        end
        chk("frac_sum16", sum, 72);

        // Reload mid-interval never truncates the running interval; last load wins.
        set_div(10, 0, s);
        wait_for(0, 30, "reload0", t0);
        chk("reload_first", t0 - s, 10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        load = 1'b1; div_int = 16'd3; div_frac = 4'd0;
        @(negedge clk);
        load = 1'b0;
        wait_for(0, 30, "reload1", t1);
        chk("reload_old_interval", t1 - t0, 10);
        wait_for(0, 30, "reload2", t2);
        chk("reload_new_interval", t2 - t1, 3);
        wait_for(0, 30, "reload3", t3);
        chk("reload_new_interval2", t3 - t2, 3);
        @(negedge clk);
        load = 1'b1; div_int = 16'd7;
        @(negedge clk);
        div_int = 16'd5;
        @(negedge clk);
        load = 1'b0;
        wait_for(0, 30, "dbl0", t0);
        chk("double_load_current", t0 - t3, 3);
        wait_for(0, 30, "dbl1", t1);
        chk("double_load_applied", t1 - t0, 5);
        wait_for(0, 30, "dbl2", t2);
        chk("double_load_applied2", t2 - t1, 5);

        // Resync coincident with terminal count.
        set_div(8, 0, s);
        wait_for(0, 30, "rs0", t0);
        chk("resync_pre_tick", t0 - s, 8);
        chk("resync_pre_phase", int'(os_phase), 1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        chk("resync_no_tick", int'(os_tick), 0);
        chk("resync_phase", int'(os_phase), 0);
        wait_for(0, 30, "rs1", t1);
        chk("resync_next_tick", t1 - (t0 + 8), 8);
        mid_at = mid_tick ? 1 : 0;
        bit_at = bit_tick ? 1 : 0;
        for (int i = 2; i <= 16; i++) begin
            wait_for(0, 30, "rs_seq", t2);
            if (mid_tick) mid_at = i;
            if (bit_tick) bit_at = i;
        end
        chk("resync_mid_index", mid_at, 8);
        chk("resync_bit_index", bit_at, 16);

        // Clamp of 0 and 1 to 2, then enable drop mid-interval.
        set_div(0, 0, s);
        wait_for(0, 10, "clamp0a", t0);
        chk("clamp0_first", t0 - s, 2);
        wait_for(0, 10, "clamp0b", t1);
        chk("clamp0_period", t1 - t0, 2);
        set_div(1, 0, s);
        wait_for(0, 10, "clamp1a", t0);
        chk("clamp1_first", t0 - s, 2);
        wait_for(0, 10, "clamp1b", t1);
        chk("clamp1_period", t1 - t0, 2);
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("disabled_phase", int'(os_phase), 0);
        enable = 1'b1;
        s = cyc;
        wait_for(0, 10, "reenable", t2);
        chk("reenable_first", t2 - s, 2);

        repeat (3) @(negedge clk);
        summary_and_finish();
    end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud-rate tick generator for the UART. It replaces the fixed single-rate enable divider with a runtime-programmable integer+fractional divisor. It produces an oversample tick for the receiver, plus bit-rate and mid-bit ticks derived from it. A resync input lets the RX framer realign the tick phase to a start-bit edge. It sits between the system clock domain and the UART TX/RX framers; all ticks are single-cycle clock enables, never clocks.

## Interface
- `DIV_W`, 16: width of integer divisor (clock cycles per oversample tick).
- `FRAC_W`, 4: width of fractional divisor (units of 1/2^FRAC_W cycle).
- `OVERSAMPLE`, 16: oversample ticks per bit; power of two, ≥4.
- `DEFAULT_DIV`, 5300: integer divisor loaded at reset; fractional part resets to 0.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run generator; low holds all phase state cleared.
- `load`  in  1  capture `div_int`/`div_frac` into the shadow register this cycle.
- `div_int`  in  DIV_W  integer divisor; values <2 are treated as 2.
- `div_frac`  in  FRAC_W  fractional divisor.
- `resync`  in  1  restart tick phase (RX start-bit alignment).
- `os_tick`  out  1  one-cycle oversample enable.
- `bit_tick`  out  1  one-cycle bit-rate enable, coincident with `os_tick`.
- `mid_tick`  out  1  one-cycle mid-bit enable, coincident with `os_tick`.
- `os_phase`  out  log2(OVERSAMPLE)  current oversample index within the bit.

## Operation
- State: cycle counter `cnt` (DIV_W), fraction accumulator `acc` (FRAC_W), carry flag `xtra`, `os_phase`, active divisor `{a_int,a_frac}`, shadow divisor plus `pend` flag.
- Period of each oversample interval = `a_int + xtra` cycles.
- Counting: `cnt` increments each enabled cycle. When `cnt == a_int + xtra - 1`:
  - `cnt` goes to 0.
  - `os_tick` is asserted the following cycle.
  - `{xtra, acc}` is set to `acc + a_frac`, with the carry going to `xtra`.
- Fraction: over 2^FRAC_W consecutive intervals, exactly `a_frac` of them are one cycle longer.
- `os_phase` increments (mod OVERSAMPLE) on every `os_tick`.
  - `bit_tick` asserts with the `os_tick` on which `os_phase` wraps OVERSAMPLE-1→0.
  - `mid_tick` asserts with the `os_tick` on which `os_phase` moves OVERSAMPLE/2-1→OVERSAMPLE/2.
- Divisor update:
  - `load` captures the inputs into the shadow and sets `pend`.
  - When enabled, the shadow is copied to the active divisor at the next interval boundary (the same edge `cnt` returns to 0). A running interval is never truncated or stretched.
  - A second `load` before that boundary overwrites the shadow; the last value wins.
- `enable` low:
  - `cnt`, `acc`, `xtra` and `os_phase` are held at 0 and all ticks are 0.
  - A pending shadow is applied immediately.
- `resync` (enabled):
  - Clears `cnt`, `acc`, `xtra` and `os_phase`; applies a pending shadow; no tick in that cycle.
  - Has priority over a coincident terminal count, so that tick is suppressed.
- Reset: active divisor = `{DEFAULT_DIV, 0}`, shadow = same, `pend`=0, all counters 0. `os_tick`/`bit_tick`/`mid_tick` = 0 and `os_phase` = 0.

## Timing
- All outputs are registered; no combinational input→output path.
- With `enable`=1 held from reset release and a divisor of N with frac 0:
  - the first `os_tick` occurs on the Nth rising edge after release;
  - `os_tick` then pulses every N cycles.
- The first `bit_tick` occurs after OVERSAMPLE·N cycles.
- After `resync` is sampled high, the next `os_tick` comes exactly `a_int` cycles later.
- Pulses are exactly one cycle wide, never back-to-back (period ≥2).
- `load`, `resync` and `enable` are sampled synchronously.
- Reset assertion clears everything asynchronously at any point, including mid-interval.

## Structure
- The shared UART constants file holds `DIV_W`/`FRAC_W` defaults, `DEFAULT_DIV`, the OVERSAMPLE default, and a clog2 helper for the `os_phase` width.
- One sub-module, `uart_frac_div`: the counter, accumulator and `xtra` logic, producing the raw `os_tick`.
- The top level holds the shadow/pend logic, the `os_phase` counter, and bit/mid decode.

## Test plan
- Reset default: release reset, `enable`=1, no load. Required: `os_tick` every 5300 cycles; `bit_tick` at cycle 84800; all outputs 0 during reset.
- Fraction: load `div_int`=4, `div_frac`=8, with FRAC_W=4. Required:
  - interval lengths 4,4,5,4,5,…;
  - 16 consecutive intervals total 72 cycles.
- Glitch-free reload: `div_int`=10 running; load 3 at `cnt`=4. Required: the current interval still lasts 10 cycles, then intervals of 3. Two loads (7 then 5) within one interval: 5 applied.
- Resync: `div_int`=8, assert `resync` on the same cycle as a terminal count. Required:
  - no `os_tick` that cycle, `os_phase`=0;
  - next `os_tick` 8 cycles later;
  - `mid_tick` on the 8th `os_tick` after resync, `bit_tick` on the 16th.
- Clamp/enable: `div_int`=0 or 1. Required: `os_tick` every 2 cycles. Drop `enable` mid-interval: ticks stop at once, and on re-enable the first tick comes a full period later.
- Async reset mid-interval: assert `reset` low between edges. Required: outputs go to 0 immediately, and after release the default 5300 divisor is restored even if another value was loaded.
